// File: rtl/pipo_load_arbiter_if.sv
// Bundle of request/data/grant signals between the requesters and the
// shared holding-register arbiter.
interface pipo_load_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) ();
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] din;
  logic                     clr;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         Q;
  logic                     q_valid;
  logic [IDW-1:0]           owner;
  logic                     busy;

  // Requester side: drives requests, words and clear; observes the register.
  modport master (
    output req, din, clr,
    input  gnt, Q, q_valid, owner, busy
  );

  // Arbiter side.
  modport slave (
    input  req, din, clr,
    output gnt, Q, q_valid, owner, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter sharing one parallel-in/parallel-out register among
// NUM_REQ requesters. A granted word is held for HOLD_CYCLES cycles before
// the next arbitration; all outputs are registered.
module pipo_load_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input logic                clk,
  input logic                reset,
  pipo_load_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [7:0]     HOLD_LOAD = 8'(HOLD_CYCLES);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);

  // Requester index at offset 'off' from 'base', wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  logic [0:0]         r_state;
  logic [7:0]         r_cnt;
  logic [IDW-1:0]     r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;
  logic [IDW-1:0]     r_owner;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_next_ptr;
  logic [WIDTH-1:0]   w_word;
  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic               w_load;

  // Round-robin search: scanning offsets from far to near lets the nearest
  // set request (starting at r_ptr) be the last, and therefore winning, write.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[rr_index(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_index(r_ptr, k);
      end
    end
  end

  assign w_next_ptr   = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
  assign w_word       = bus.din[int'(w_win)*WIDTH +: WIDTH];
  assign w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

  // A load happens only from IDLE with a live request; clr suppresses it.
  assign w_load = (r_state == ST_IDLE) && w_found && !bus.clr;

  // Arbitration control: state, hold counter, pointer and grant pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else if (bus.clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_gnt_onehot;
            r_ptr   <= w_next_ptr;
            r_cnt   <= HOLD_LOAD;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Shared register contents and ownership; owner survives clr so the
  // downstream side can still tell who last wrote.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
    end else if (bus.clr) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_load) begin
      r_q       <= w_word;
      r_q_valid <= 1'b1;
      r_owner   <= w_win;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.Q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.owner   = r_owner;
  assign bus.busy    = (r_state == ST_HOLD);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: three instances (hold 2, 1, 4) share one
// stimulus stream and are compared against a transaction-level model.
module tb_pipo_load_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic          clk;
  logic          reset;
  logic          clr;
  logic [N-1:0]  req;
  logic [N*W-1:0] din;

  int checks;
  int failures;

  pipo_load_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus0 ();
  pipo_load_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus1 ();
  pipo_load_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus2 ();

  assign bus0.req = req; assign bus0.din = din; assign bus0.clr = clr;
  assign bus1.req = req; assign bus1.din = din; assign bus1.clr = clr;
  assign bus2.req = req; assign bus2.din = din; assign bus2.clr = clr;

  pipo_load_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  pipo_load_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  pipo_load_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {gnt, Q, q_valid, owner, busy}.
  logic [11:0] obs [3];
  assign obs[0] = {bus0.gnt, bus0.Q, bus0.q_valid, bus0.owner, bus0.busy};
  assign obs[1] = {bus1.gnt, bus1.Q, bus1.q_valid, bus1.owner, bus1.busy};
  assign obs[2] = {bus2.gnt, bus2.Q, bus2.q_valid, bus2.owner, bus2.busy};

  // Transaction-level model: 'left' = remaining hold cycles.
  typedef struct {
    int         left;
    int         ptr;
    logic [3:0] q;
    logic       qv;
    int         owner;
    logic [3:0] gnt;
  } mdl_t;

  mdl_t m [3];
  int   hold_of [3] = '{2, 1, 4};

  function automatic int find_winner(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [11:0] exp_vec(input int i);
    return {m[i].gnt, m[i].q, m[i].qv, 2'(m[i].owner), (m[i].left > 0)};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int w;
      if (reset) begin
        m[i].left = 0; m[i].ptr = 0; m[i].q = 4'h0; m[i].qv = 1'b0;
        m[i].owner = 0; m[i].gnt = 4'h0;
      end else if (clr) begin
        m[i].left = 0; m[i].q = 4'h0; m[i].qv = 1'b0; m[i].gnt = 4'h0;
      end else if (m[i].left > 0) begin
        m[i].gnt = 4'h0;
        m[i].left = m[i].left - 1;
      end else begin
        m[i].gnt = 4'h0;
        w = find_winner(m[i].ptr, req);
        if (w >= 0) begin
          m[i].q     = din[w*W +: W];
          m[i].qv    = 1'b1;
          m[i].owner = w;
          m[i].gnt   = 4'(1 << w);
          m[i].ptr   = (w + 1) % N;
          m[i].left  = hold_of[i];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; din = 16'h5A5A; clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== 12'h000) begin
          failures++;
          $display("FAIL reset_hold inst%0d got=%h want=%h", i, obs[i], 12'h000);
        end
      end
    end
    reset = 1'b0; req = '0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== 12'h000 || obs[i] !== exp_vec(i)) begin
          failures++;
          $display("FAIL reset_idle inst%0d got=%h want=%h", i, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_single();
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 4'b0100; din = 16'h0A00;
    cyc();
    checks++;
    if ({bus0.gnt, bus0.Q, bus0.q_valid, bus0.owner, bus0.busy} !== {4'b0100, 4'hA, 1'b1, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL single_grant got=%h want=%h", obs[0], {4'b0100, 4'hA, 1'b1, 2'd2, 1'b1});
    end
    req = '0;
    cyc();
    checks++;
    if ({bus0.gnt, bus0.Q, bus0.busy} !== {4'b0000, 4'hA, 1'b1}) begin
      failures++;
      $display("FAIL single_hold got=%h want=%h", {bus0.gnt, bus0.Q, bus0.busy}, {4'b0000, 4'hA, 1'b1});
    end
    cyc();
    checks++;
    if ({bus0.busy, bus0.Q, bus0.q_valid} !== {1'b0, 4'hA, 1'b1}) begin
      failures++;
      $display("FAIL single_idle got=%h want=%h", {bus0.busy, bus0.Q, bus0.q_valid}, {1'b0, 4'hA, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_vec(i)) begin
        failures++;
        $display("FAIL single_model inst%0d got=%h want=%h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_wrap();
    // Previous test left dut0 idle with ptr at 3.
    req = 4'b0011;
    cyc();
    checks++;
    if ({bus0.gnt, bus0.owner} !== {4'b0001, 2'd0}) begin
      failures++;
      $display("FAIL wrap_grant got=%b/%0d want=0001/0", bus0.gnt, bus0.owner);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_vec(i)) begin
        failures++;
        $display("FAIL wrap_model inst%0d got=%h want=%h", i, obs[i], exp_vec(i));
      end
    end
    req = '0;
    for (int c = 0; c < 5; c++) cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] words [4];
    logic [3:0] eg;
    logic [3:0] eq;
    words = '{4'h1, 4'h2, 4'h3, 4'h4};
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 4'b1111; din = 16'h4321;
    for (int k = 0; k < 10; k++) begin
      cyc();
      eg = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'b0000;
      eq = words[(k / 2) % 4];
      checks++;
      if ({bus1.gnt, bus1.Q} !== {eg, eq}) begin
        failures++;
        $display("FAIL rr_seq cyc%0d got=%b/%h want=%b/%h", k, bus1.gnt, bus1.Q, eg, eq);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          failures++;
          $display("FAIL rr_model inst%0d cyc%0d got=%h want=%h", i, k, obs[i], exp_vec(i));
        end
      end
    end
    req = '0;
  endtask

  task automatic test_clr();
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 4'b0010; din = 16'h00C0; clr = 1'b1;
    cyc();
    checks++;
    if ({bus0.gnt, bus0.Q, bus0.q_valid, bus0.busy} !== {4'b0000, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_beats_grant got=%h want=%h", {bus0.gnt, bus0.Q, bus0.q_valid, bus0.busy}, 10'h0);
    end
    clr = 1'b0;
    cyc();
    checks++;
    if ({bus0.gnt, bus0.owner, bus0.Q} !== {4'b0010, 2'd1, 4'hC}) begin
      failures++;
      $display("FAIL clr_then_grant got=%b/%0d/%h want=0010/1/c", bus0.gnt, bus0.owner, bus0.Q);
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_vec(i)) begin
        failures++;
        $display("FAIL clr_model inst%0d got=%h want=%h", i, obs[i], exp_vec(i));
      end
    end
    for (int c = 0; c < 5; c++) cyc();
  endtask

  task automatic test_reset_in_hold();
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 4'b0001; din = 16'h0007;
    cyc();
    req = '0;
    cyc(); cyc();
    checks++;
    if (bus2.busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold_busy got=%b want=1", bus2.busy);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (obs[2] !== 12'h000) begin
      failures++;
      $display("FAIL rst_hold_values got=%h want=%h", obs[2], 12'h000);
    end
    req = 4'b1000; din = 16'h9000;
    cyc();
    checks++;
    if ({bus2.gnt, bus2.owner, bus2.Q, bus2.busy} !== {4'b1000, 2'd3, 4'h9, 1'b1}) begin
      failures++;
      $display("FAIL rst_hold_regrant got=%b/%0d/%h want=1000/3/9", bus2.gnt, bus2.owner, bus2.Q);
    end
    req = '0;
    for (int c = 0; c < 6; c++) cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      req   = 4'($urandom_range(0, 15));
      din   = 16'($urandom);
      clr   = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 63) == 0);
      cyc();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          failures++;
          $display("FAIL rand_model inst%0d cyc%0d got=%h want=%h", i, c, obs[i], exp_vec(i));
        end
      end
    end
    reset = 1'b0; clr = 1'b0; req = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; clr = 1'b0; req = '0; din = '0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_clr();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
